// File: rtl/btn_run_ctrl.sv
// -----------------------------------------------------------------------------
// btn_run_ctrl
// Control stage in front of the LED counter. Two raw, active-low push buttons
// are synchronized and debounced. Presses drive a small PAUSED/RUN/STEP FSM
// that produces the counter enable.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous, active-low reset
//   btn_run_n   raw run/pause button, active-low, asynchronous to clk
//   btn_step_n  raw single-step button, active-low, asynchronous to clk
//   en          registered counter enable:
//                 continuous in RUN, a single-cycle pulse for STEP
//   run_led     registered run-status LED, high while in RUN
//
// Parameters:
//   DB_CNT       consecutive stable cycles needed to accept a level change (>=2)
//   SYNC_STAGES  flip-flops per button synchronizer (>=2)
// -----------------------------------------------------------------------------
module btn_run_ctrl #(
  parameter int DB_CNT      = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_run_n,
  input  logic btn_step_n,
  output logic en,
  output logic run_led
);

  localparam int            CW      = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

  // Index 0 is the run button and index 1 is the step button.
  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  logic [1:0]                  btn_raw_s;
  logic [1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0][CW-1:0]          cnt_q;
  logic [1:0][CW-1:0]          cnt_d;
  logic [1:0]                  stable_q;
  logic [1:0]                  stable_d;
  logic [1:0]                  stable_dly_q;
  logic [1:0]                  press_q;
  state_e                      state_q;
  state_e                      state_d;
  logic                        en_q;
  logic                        en_d;
  logic                        run_led_q;
  logic                        run_led_d;

  assign btn_raw_s = {btn_step_n, btn_run_n};

  // Synchronizer chains. Bit 0 is the input stage, and the MSB is the only
  // stage used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {(2 * SYNC_STAGES){1'b1}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw_s[i]};
      end
    end
  end

  // Debounce next-state. Any disagreement must persist for DB_CNT cycles.
  // A single agreeing cycle restarts the count. The >= comparison brings a
  // corrupted counter back to zero instead of letting it wander.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i][SYNC_STAGES-1] == stable_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] >= CNT_MAX) begin
        stable_d[i] = sync_q[i][SYNC_STAGES-1];
        cnt_d[i]    = {CW{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounce registers plus a one-cycle press pulse.
  // Only the released-to-pressed (1 -> 0) transition produces a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {(2 * CW){1'b0}};
      stable_q     <= 2'b11;
      stable_dly_q <= 2'b11;
      press_q      <= 2'b00;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_dly_q & ~stable_q;
    end
  end

  // FSM next-state and output decode.
  // The run button has priority over the step button.
  // STEP always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSED: begin
        if (press_q[BTN_RUN]) begin
          state_d = ST_RUN;
        end else if (press_q[BTN_STEP]) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_RUN: begin
        if (press_q[BTN_RUN]) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        state_d = ST_PAUSED;
      end
      default: begin
        state_d = ST_PAUSED;
      end
    endcase
    en_d      = (state_d == ST_RUN) || (state_d == ST_STEP);
    run_led_d = (state_d == ST_RUN);
  end

  // State register and registered outputs.
  // Reset clears the outputs asynchronously, so en drops without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PAUSED;
      en_q      <= 1'b0;
      run_led_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      run_led_q <= run_led_d;
    end
  end

  assign en      = en_q;
  assign run_led = run_led_q;

endmodule

// File: tb/tb_btn_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_run_ctrl
// Self-checking bench for btn_run_ctrl with DB_CNT=4 and SYNC_STAGES=2.
// With these settings a press changes the outputs at the 8th edge.
// Each table row gives the button levels for one clock cycle and the en and
// run_led values expected just after that cycle's rising edge.
// -----------------------------------------------------------------------------
module tb_btn_run_ctrl;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic btn_run_n  = 1'b1;
  logic btn_step_n = 1'b1;
  logic en;
  logic run_led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic run_n;
    logic step_n;
    logic exp_en;
    logic exp_led;
  } vec_t;

  typedef struct {
    logic en;
    logic led;
    int   idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vec_base = 0;

  btn_run_ctrl #(
    .DB_CNT      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_run_n  (btn_run_n),
    .btn_step_n (btn_step_n),
    .en         (en),
    .run_led    (run_led)
  );

  always #5 clk = ~clk;

  // Append n rows that share the same button levels and expected outputs.
  task automatic add(input int n, input logic r, input logic s, input logic e, input logic l);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.run_n   = r;
      v.step_n  = s;
      v.exp_en  = e;
      v.exp_led = l;
      vecs.push_back(v);
    end
  endtask

  // Compare one output bit and report any difference.
  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  // Apply the table. Inputs change at the falling edge.
  // Outputs are sampled 1 ns after the rising edge.
  task automatic run_vecs();
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      btn_run_n  = vecs[i].run_n;
      btn_step_n = vecs[i].step_n;
      e.en  = vecs[i].exp_en;
      e.led = vecs[i].exp_led;
      e.idx = vec_base + i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: actual 0 entries required 1");
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d_en", e.idx), en, e.en);
        check($sformatf("vec%0d_run_led", e.idx), run_led, e.led);
      end
    end
    vec_base += vecs.size();
    vecs.delete();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset with both buttons released.
    repeat (3) @(posedge clk);
    #1;
    check("reset_en", en, 1'b0);
    check("reset_run_led", run_led, 1'b0);
    rst_n = 1'b1;

    // 1: idle with both buttons released.
    add(20, 1'b1, 1'b1, 1'b0, 1'b0);

    // 2: run press held enters RUN at edge 8.
    //    After a debounced release, a second press returns to PAUSED at edge 8.
    add(7,  1'b0, 1'b1, 1'b0, 1'b0);
    add(5,  1'b0, 1'b1, 1'b1, 1'b1);
    add(10, 1'b1, 1'b1, 1'b1, 1'b1);
    add(7,  1'b0, 1'b1, 1'b1, 1'b1);
    add(3,  1'b0, 1'b1, 1'b0, 1'b0);
    add(10, 1'b1, 1'b1, 1'b0, 1'b0);

    // 3: step held for 30 cycles gives one en pulse at edge 8.
    //    run_led stays low throughout.
    add(7,  1'b1, 1'b0, 1'b0, 1'b0);
    add(1,  1'b1, 1'b0, 1'b1, 1'b0);
    add(22, 1'b1, 1'b0, 1'b0, 1'b0);
    add(10, 1'b1, 1'b1, 1'b0, 1'b0);

    // 4: bounce 3 low, 1 high, 3 low, 1 high gives no change.
    //    The following stable low enters RUN 8 edges after it begins.
    add(3,  1'b0, 1'b1, 1'b0, 1'b0);
    add(1,  1'b1, 1'b1, 1'b0, 1'b0);
    add(3,  1'b0, 1'b1, 1'b0, 1'b0);
    add(1,  1'b1, 1'b1, 1'b0, 1'b0);
    add(7,  1'b0, 1'b1, 1'b0, 1'b0);
    add(3,  1'b0, 1'b1, 1'b1, 1'b1);
    add(10, 1'b1, 1'b1, 1'b1, 1'b1);
    // Pause again before the next scenario.
    add(7,  1'b0, 1'b1, 1'b1, 1'b1);
    add(3,  1'b0, 1'b1, 1'b0, 1'b0);
    add(10, 1'b1, 1'b1, 1'b0, 1'b0);

    // 5: simultaneous presses give RUN with no step pulse.
    //    A step press while in RUN changes nothing.
    add(7,  1'b0, 1'b0, 1'b0, 1'b0);
    add(5,  1'b0, 1'b0, 1'b1, 1'b1);
    add(10, 1'b1, 1'b1, 1'b1, 1'b1);
    add(12, 1'b1, 1'b0, 1'b1, 1'b1);
    add(10, 1'b1, 1'b1, 1'b1, 1'b1);
    run_vecs();

    // 6: asynchronous reset while in RUN, asserted between edges.
    @(negedge clk);
    check("pre_reset_en", en, 1'b1);
    check("pre_reset_run_led", run_led, 1'b1);
    btn_run_n = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_en", en, 1'b0);
    check("async_reset_run_led", run_led, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("held_reset_en", en, 1'b0);
    check("held_reset_run_led", run_led, 1'b0);
    rst_n = 1'b1;

    // The button held low through reset release counts as a new press.
    add(7,  1'b0, 1'b1, 1'b0, 1'b0);
    add(4,  1'b0, 1'b1, 1'b1, 1'b1);
    add(10, 1'b1, 1'b1, 1'b1, 1'b1);
    run_vecs();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d entries required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
